// File: rtl/pir_stim_sequencer.sv
// Table-driven stimulus source for the PIR motion-detection datapath.
// Each table entry drives all outputs for a programmed dwell; runs are one-shot or looping.
module pir_stim_sequencer #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 7,
  parameter int DEPTH  = 16,
  parameter int DUR_W  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = NUM_CH * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [PW-1:0]     cfg_pir,
  input  logic              cfg_turn,
  input  logic              cfg_stop_alarm,
  input  logic [DUR_W-1:0]  cfg_dur,
  input  logic [AW:0]       num_steps,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  output logic [PW-1:0]     pir_sensor,
  output logic              turn,
  output logic              stop_alarm,
  output logic              busy,
  output logic              done,
  output logic [AW-1:0]     step_idx,
  output logic [7:0]        loop_count
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_S = (AW+1)'(DEPTH);

  logic [PW-1:0]    tbl_pir_r  [DEPTH];
  logic             tbl_turn_r [DEPTH];
  logic             tbl_stop_r [DEPTH];
  logic [DUR_W-1:0] tbl_dur_r  [DEPTH];

  state_t           state_r, state_s;
  logic [PW-1:0]    pir_r, pir_s;
  logic             turn_r, turn_s, stop_r, stop_s, busy_r, busy_s, done_r, done_s;
  logic [AW-1:0]    step_r, step_s, load_idx_s;
  logic [7:0]       lc_r, lc_s;
  logic [DUR_W-1:0] dwell_r, dwell_s;
  logic [AW:0]      nsteps_r, nsteps_s, nsteps_clamp_s;
  logic             load_s;

  assign nsteps_clamp_s = (num_steps > DEPTH_S) ? DEPTH_S : num_steps;

  // Step table storage; writes are locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_r) begin
      tbl_pir_r[cfg_addr]  <= cfg_pir;
      tbl_turn_r[cfg_addr] <= cfg_turn;
      tbl_stop_r[cfg_addr] <= cfg_stop_alarm;
      tbl_dur_r[cfg_addr]  <= cfg_dur;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN sequencer.
  always_comb begin
    state_s    = state_r;
    pir_s      = pir_r;
    turn_s     = turn_r;
    stop_s     = stop_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    step_s     = step_r;
    lc_s       = lc_r;
    dwell_s    = dwell_r;
    nsteps_s   = nsteps_r;
    load_s     = 1'b0;
    load_idx_s = {AW{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if (start && (num_steps == {(AW+1){1'b0}})) begin
          done_s = 1'b1;
        end else if (start && !abort) begin
          state_s  = ST_RUN;
          busy_s   = 1'b1;
          lc_s     = 8'd0;
          nsteps_s = nsteps_clamp_s;
          load_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
          pir_s   = {PW{1'b0}};
          turn_s  = 1'b0;
          stop_s  = 1'b0;
          busy_s  = 1'b0;
        end else if (dwell_r != {DUR_W{1'b0}}) begin
          dwell_s = dwell_r - DUR_W'(1);
        end else if (({1'b0, step_r} + (AW+1)'(1)) < nsteps_r) begin
          load_s     = 1'b1;
          load_idx_s = step_r + AW'(1);
        end else if (loop_en) begin
          load_s = 1'b1;
          lc_s   = (lc_r == 8'd255) ? 8'd255 : lc_r + 8'd1;
        end else begin
          state_s = ST_IDLE;
          pir_s   = {PW{1'b0}};
          turn_s  = 1'b0;
          stop_s  = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pir_s   = {PW{1'b0}};
        turn_s  = 1'b0;
        stop_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
    // A zero dwell count still shows the entry for one cycle.
    if (load_s) begin
      pir_s   = tbl_pir_r[load_idx_s];
      turn_s  = tbl_turn_r[load_idx_s];
      stop_s  = tbl_stop_r[load_idx_s];
      step_s  = load_idx_s;
      dwell_s = (tbl_dur_r[load_idx_s] == {DUR_W{1'b0}}) ? {DUR_W{1'b0}}
                                                         : tbl_dur_r[load_idx_s] - DUR_W'(1);
    end else begin
      load_idx_s = {AW{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      pir_r    <= {PW{1'b0}};
      turn_r   <= 1'b0;
      stop_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      step_r   <= {AW{1'b0}};
      lc_r     <= 8'd0;
      dwell_r  <= {DUR_W{1'b0}};
      nsteps_r <= {(AW+1){1'b0}};
    end else begin
      state_r  <= state_s;
      pir_r    <= pir_s;
      turn_r   <= turn_s;
      stop_r   <= stop_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      step_r   <= step_s;
      lc_r     <= lc_s;
      dwell_r  <= dwell_s;
      nsteps_r <= nsteps_s;
    end
  end

  assign pir_sensor = pir_r;
  assign turn       = turn_r;
  assign stop_alarm = stop_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign step_idx   = step_r;
  assign loop_count = lc_r;

endmodule

// File: tb/tb_pir_stim_sequencer.sv
// Bench for pir_stim_sequencer: a table model expands each run into the expected
// per-cycle output trace, which is compared against the DUT every cycle.
module tb_pir_stim_sequencer;
  localparam int NUM_CH = 3, DATA_W = 7, DEPTH = 16, DUR_W = 16;
  localparam int AW = $clog2(DEPTH), PW = NUM_CH * DATA_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cfg_we, cfg_turn, cfg_stop_alarm, loop_en, start, abort;
  logic [AW-1:0] cfg_addr;
  logic [PW-1:0] cfg_pir;
  logic [DUR_W-1:0] cfg_dur;
  logic [AW:0] num_steps;
  logic [PW-1:0] pir_sensor;
  logic turn, stop_alarm, busy, done;
  logic [AW-1:0] step_idx;
  logic [7:0] loop_count;

  pir_stim_sequencer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pir(cfg_pir),
    .cfg_turn(cfg_turn), .cfg_stop_alarm(cfg_stop_alarm), .cfg_dur(cfg_dur),
    .num_steps(num_steps), .loop_en(loop_en), .start(start), .abort(abort),
    .pir_sensor(pir_sensor), .turn(turn), .stop_alarm(stop_alarm), .busy(busy),
    .done(done), .step_idx(step_idx), .loop_count(loop_count));

  typedef struct packed {
    logic [PW-1:0] pir; logic turn; logic stop; logic busy; logic done;
    logic [AW-1:0] step; logic [7:0] lc;
  } obs_t;

  obs_t q[$];
  logic [PW-1:0] m_pir [DEPTH];
  logic m_turn [DEPTH];
  logic m_stop [DEPTH];
  int m_dur [DEPTH];
  int n_checks = 0, n_fail = 0;

  function automatic obs_t observe();
    obs_t o;
    o = {pir_sensor, turn, stop_alarm, busy, done, step_idx, loop_count};
    return o;
  endfunction

  task automatic check(input string tag, input int idx, input logic [63:0] o, input logic [63:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, o, e);
    end
  endtask

  task automatic wr(input int a, input logic [PW-1:0] p, input logic t, input logic s, input int d);
    cfg_we = 1'b1; cfg_addr = a[AW-1:0]; cfg_pir = p; cfg_turn = t; cfg_stop_alarm = s;
    cfg_dur = d[DUR_W-1:0];
    @(posedge clk); @(negedge clk);
    cfg_we = 1'b0;
    m_pir[a] = p; m_turn[a] = t; m_stop[a] = s; m_dur[a] = d;
  endtask

  task automatic fill_random();
    for (int a = 0; a < DEPTH; a++)
      wr(a, PW'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
  endtask

  // Expected trace: every pass shows entries 0..n-1 for max(dur,1) cycles, then a
  // zeroed done cycle and one idle cycle.
  task automatic build(input int n, input int passes, output int pass_len);
    obs_t e;
    q.delete();
    pass_len = 0;
    for (int k = 0; k < n; k++) pass_len += (m_dur[k] == 0) ? 1 : m_dur[k];
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < n; k++)
        for (int r = 0; r < ((m_dur[k] == 0) ? 1 : m_dur[k]); r++) begin
          e.pir = m_pir[k]; e.turn = m_turn[k]; e.stop = m_stop[k]; e.busy = 1'b1;
          e.done = 1'b0; e.step = k[AW-1:0]; e.lc = (p > 255) ? 8'd255 : 8'(p);
          q.push_back(e);
        end
    e = '0;
    e.done = 1'b1; e.step = AW'(n - 1); e.lc = (passes - 1 > 255) ? 8'd255 : 8'(passes - 1);
    q.push_back(e);
    e.done = 1'b0;
    q.push_back(e);
  endtask

  task automatic run(input string tag, input int n_req, input int passes, input int abort_at,
                     input int wr_at);
    int n, plen, clear_at;
    obs_t o;
    n = (n_req > DEPTH) ? DEPTH : n_req;
    build(n, passes, plen);
    clear_at = (passes > 1) ? (passes - 1) * plen : -1;
    num_steps = n_req[AW:0]; loop_en = (passes > 1); start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      check(tag, i, 64'(observe()), 64'(q[i]));
      cfg_we = 1'b0;
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clk); @(negedge clk);
        abort = 1'b0;
        o = observe();
        check({tag, "_abort"}, i, 64'(o[36:12]), 64'(0));
        @(posedge clk); @(negedge clk);
        o = observe();
        check({tag, "_after_abort"}, i, 64'(o[36:12]), 64'(0));
        return;
      end
      if (i == clear_at) loop_en = 1'b0;
      if (i == wr_at) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_pir = ~m_pir[0]; cfg_turn = ~m_turn[0];
        cfg_stop_alarm = ~m_stop[0]; cfg_dur = DUR_W'(m_dur[0] + 3);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int np;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_pir = '0; cfg_turn = 1'b0;
    cfg_stop_alarm = 1'b0; cfg_dur = '0; num_steps = '0; loop_en = 1'b0; start = 1'b0;
    abort = 1'b0;
    #12;
    check("reset", 0, 64'(observe()), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    fill_random();

    // T1: three entries of 5, 5 and 51 cycles
    wr(0, {7'd56, 7'd0, 7'd29}, 1'b1, 1'b0, 5);
    wr(1, {PW{1'b0}}, 1'b1, 1'b0, 5);
    wr(2, {PW{1'b0}}, 1'b0, 1'b0, 51);
    run("t1", 3, 1, -1, -1);

    // T2: zero dwell on every entry
    for (int a = 0; a < 4; a++) wr(a, PW'($urandom), 1'($urandom), 1'($urandom), 0);
    run("t2", 4, 1, -1, -1);

    // T3: looping with saturation of loop_count, then completion
    wr(0, PW'($urandom), 1'b1, 1'b0, 1);
    wr(1, PW'($urandom), 1'b0, 1'b1, 1);
    run("t3", 2, 301, -1, -1);

    // T4: abort on the last dwell cycle of entry1
    wr(0, PW'($urandom), 1'b1, 1'b1, 2);
    wr(1, PW'($urandom), 1'b0, 1'b1, 3);
    wr(2, PW'($urandom), 1'b1, 1'b0, 4);
    run("t4", 3, 1, 4, -1);

    // T5: writes while busy are ignored
    run("t5", 3, 1, -1, 1);
    run("t5_rerun", 3, 1, -1, -1);

    // num_steps beyond DEPTH is clamped
    fill_random();
    run("clamp", DEPTH + 5, 1, -1, -1);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      np = (r % 2 == 1) ? int'($urandom_range(2, 3)) : 1;
      run("rand", int'($urandom_range(1, DEPTH + 3)), np, -1, -1);
    end

    // T6: asynchronous reset mid-run, then start with num_steps=0
    wr(0, PW'($urandom) | PW'(1), 1'b1, 1'b1, 10);
    num_steps = (AW+1)'(1); loop_en = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_async_reset", 0, 64'(observe()), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t6_no_done", 0, 64'(observe()), 64'(0));
    num_steps = '0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    o = '0; o.done = 1'b1;
    check("t6_zero_steps_done", 0, 64'(observe()), 64'(o));
    @(posedge clk); @(negedge clk);
    check("t6_zero_steps_idle", 0, 64'(observe()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
